// File: rtl/axi_lite_adder_bank.sv
// Purpose: AXI4-Lite slave with NUM_CH adder channels (A, B, SUM, sticky STATUS) plus global CTRL/INFO.
// Latency: B one cycle after the later of AW/W; SUM/STATUS one cycle after an operand write; R one cycle after AR.
// Backpressure: AW/W/AR each take one beat, then hold ready low until the matching B or R handshake completes.
module axi_lite_adder_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                      s1_axi_aclk,
    input  logic                      s1_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
    input  logic                      s1_axi_awvalid,
    output logic                      s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
    input  logic                      s1_axi_wvalid,
    output logic                      s1_axi_wready,
    output logic [1:0]                s1_axi_bresp,
    output logic                      s1_axi_bvalid,
    input  logic                      s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
    input  logic                      s1_axi_arvalid,
    output logic                      s1_axi_arready,
    output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
    output logic [1:0]                s1_axi_rresp,
    output logic                      s1_axi_rvalid,
    input  logic                      s1_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        REG_A,
        REG_B,
        REG_SUM,
        REG_STATUS,
        REG_CTRL,
        REG_INFO,
        REG_NONE
    } reg_kind_t;

    typedef struct packed {
        reg_kind_t  kind;
        logic [2:0] ch;
    } reg_sel_t;

    // Word index [7:2] -> register kind and channel; channels beyond NUM_CH are unmapped.
    function automatic reg_sel_t decode(input logic [5:0] idx);
        reg_sel_t sel;
        sel.kind = REG_NONE;
        sel.ch   = idx[4:2];
        if (!idx[5]) begin
            if (int'(idx[4:2]) < NUM_CH) begin
                case (idx[1:0])
                    2'd0: sel.kind = REG_A;
                    2'd1: sel.kind = REG_B;
                    2'd2: sel.kind = REG_SUM;
                    2'd3: sel.kind = REG_STATUS;
                endcase
            end
        end else if (idx == 6'h20) begin
            sel.kind = REG_CTRL;
        end else if (idx == 6'h21) begin
            sel.kind = REG_INFO;
        end
        return sel;
    endfunction

    // Byte-lane merge: strobed lanes take the new data, others keep the old value.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Handshakes
    logic aw_fire, w_fire, ar_fire, b_fire, r_fire;

    // Latched write address/data for the decoupled AW/W case
    logic [5:0]            awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;

    // Effective write command for this cycle
    logic [5:0]            wr_idx;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [STRB_WIDTH-1:0] wr_strb;
    reg_sel_t              wr_sel;
    logic                  wr_go;
    logic                  wr_err;

    // Register file
    logic                  en_q;
    logic [DATA_WIDTH-1:0] a_q      [NUM_CH];
    logic [DATA_WIDTH-1:0] b_q      [NUM_CH];
    logic [DATA_WIDTH-1:0] sum_q    [NUM_CH];
    logic [1:0]            status_q [NUM_CH];
    logic [NUM_CH-1:0]     sum_pend_q;

    // Per-channel combinational helpers
    logic [DATA_WIDTH:0]   add_full   [NUM_CH];
    logic [NUM_CH-1:0]     add_ovf;
    logic [NUM_CH-1:0]     ch_wr;
    logic [1:0]            status_clr [NUM_CH];

    // Read decode
    reg_sel_t              rd_sel;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_err;

    // Address bits outside [7:2] never take part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s1_axi_awaddr, s1_axi_araddr};

    assign aw_fire = s1_axi_awvalid && s1_axi_awready;
    assign w_fire  = s1_axi_wvalid  && s1_axi_wready;
    assign ar_fire = s1_axi_arvalid && s1_axi_arready;
    assign b_fire  = s1_axi_bvalid  && s1_axi_bready;
    assign r_fire  = s1_axi_rvalid  && s1_axi_rready;

    // A ready that is still high means that beat has not been latched yet, so use the live bus.
    assign wr_idx  = s1_axi_awready ? s1_axi_awaddr[7:2] : awidx_q;
    assign wr_dat  = s1_axi_wready  ? s1_axi_wdata       : wdata_q;
    assign wr_strb = s1_axi_wready  ? s1_axi_wstrb       : wstrb_q;
    assign wr_sel  = decode(wr_idx);
    assign wr_go   = (aw_fire || !s1_axi_awready) && (w_fire || !s1_axi_wready) && !s1_axi_bvalid;
    assign wr_err  = (wr_sel.kind == REG_SUM) || (wr_sel.kind == REG_INFO) || (wr_sel.kind == REG_NONE);

    // Adder, carry/overflow and per-channel write/clear strobes
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            add_full[c]   = {1'b0, a_q[c]} + {1'b0, b_q[c]};
            add_ovf[c]    = (a_q[c][DATA_WIDTH-1] == b_q[c][DATA_WIDTH-1]) &&
                            (add_full[c][DATA_WIDTH-1] != a_q[c][DATA_WIDTH-1]);
            ch_wr[c]      = wr_go && (wr_sel.ch == 3'(c));
            status_clr[c] = (ch_wr[c] && (wr_sel.kind == REG_STATUS) && wr_strb[0]) ? wr_dat[1:0] : 2'b00;
        end
    end

    // Write channel handshake: latch AW and W independently, respond once both are present
    always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
        if (s1_axi_areset) begin
            s1_axi_awready <= 1'b1;
            s1_axi_wready  <= 1'b1;
            s1_axi_bvalid  <= 1'b0;
            s1_axi_bresp   <= 2'b00;
            awidx_q        <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
        end else begin
            if (aw_fire) begin
                s1_axi_awready <= 1'b0;
                awidx_q        <= s1_axi_awaddr[7:2];
            end
            if (w_fire) begin
                s1_axi_wready <= 1'b0;
                wdata_q       <= s1_axi_wdata;
                wstrb_q       <= s1_axi_wstrb;
            end
            if (wr_go) begin
                s1_axi_bvalid <= 1'b1;
                s1_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (b_fire) begin
                s1_axi_bvalid  <= 1'b0;
                s1_axi_awready <= 1'b1;
                s1_axi_wready  <= 1'b1;
            end
        end
    end

    // Register updates; SUM/STATUS follow an operand write by one cycle using the new operands
    always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
        if (s1_axi_areset) begin
            en_q       <= 1'b1;
            sum_pend_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                a_q[c]      <= '0;
                b_q[c]      <= '0;
                sum_q[c]    <= '0;
                status_q[c] <= 2'b00;
            end
        end else begin
            if (wr_go && (wr_sel.kind == REG_CTRL) && wr_strb[0]) begin
                en_q <= wr_dat[0];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_wr[c] && (wr_sel.kind == REG_A)) begin
                    a_q[c] <= merge_bytes(a_q[c], wr_dat, wr_strb);
                end
                if (ch_wr[c] && (wr_sel.kind == REG_B)) begin
                    b_q[c] <= merge_bytes(b_q[c], wr_dat, wr_strb);
                end
                // EN is sampled at the operand write; re-enabling later does not recompute.
                sum_pend_q[c] <= ch_wr[c] && en_q && (|wr_strb) &&
                                 ((wr_sel.kind == REG_A) || (wr_sel.kind == REG_B));
                if (sum_pend_q[c]) begin
                    sum_q[c] <= add_full[c][DATA_WIDTH-1:0];
                end
                // A fresh flag wins over a W1C clear landing in the same cycle.
                status_q[c] <= (status_q[c] & ~status_clr[c]) |
                               (sum_pend_q[c] ? {add_ovf[c], add_full[c][DATA_WIDTH]} : 2'b00);
            end
        end
    end

    // Read mux over the current (pre-update) register contents
    always_comb begin
        rd_sel = decode(s1_axi_araddr[7:2]);
        rd_val = '0;
        rd_err = 1'b0;
        case (rd_sel.kind)
            REG_CTRL: rd_val[0]   = en_q;
            REG_INFO: rd_val[7:0] = 8'(NUM_CH);
            REG_NONE: rd_err      = 1'b1;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rd_sel.ch == 3'(c)) begin
                        case (rd_sel.kind)
                            REG_A:      rd_val = a_q[c];
                            REG_B:      rd_val = b_q[c];
                            REG_SUM:    rd_val = sum_q[c];
                            REG_STATUS: rd_val = DATA_WIDTH'(status_q[c]);
                            default:    rd_val = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Read channel: capture data at AR acceptance, hold until R handshake
    always_ff @(posedge s1_axi_aclk or posedge s1_axi_areset) begin
        if (s1_axi_areset) begin
            s1_axi_arready <= 1'b1;
            s1_axi_rvalid  <= 1'b0;
            s1_axi_rdata   <= '0;
            s1_axi_rresp   <= 2'b00;
        end else if (ar_fire) begin
            s1_axi_arready <= 1'b0;
            s1_axi_rvalid  <= 1'b1;
            s1_axi_rdata   <= rd_val;
            s1_axi_rresp   <= rd_err ? 2'b10 : 2'b00;
        end else if (r_fire) begin
            s1_axi_rvalid  <= 1'b0;
            s1_axi_arready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lite_adder_bank.sv
// Purpose: scoreboard bench for axi_lite_adder_bank with directed register-map vectors.
// Latency: expects B one cycle after the later of AW/W and R one cycle after AR.
// Backpressure: holds bready/rready low in one scenario, then resets mid-transaction.
module tb_axi_lite_adder_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];

    axi_lite_adder_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CH(4)) dut (
        .s1_axi_aclk   (clk),
        .s1_axi_areset (rst),
        .s1_axi_awaddr (awaddr),
        .s1_axi_awvalid(awvalid),
        .s1_axi_awready(awready),
        .s1_axi_wdata  (wdata),
        .s1_axi_wstrb  (wstrb),
        .s1_axi_wvalid (wvalid),
        .s1_axi_wready (wready),
        .s1_axi_bresp  (bresp),
        .s1_axi_bvalid (bvalid),
        .s1_axi_bready (bready),
        .s1_axi_araddr (araddr),
        .s1_axi_arvalid(arvalid),
        .s1_axi_arready(arready),
        .s1_axi_rdata  (rdata),
        .s1_axi_rresp  (rresp),
        .s1_axi_rvalid (rvalid),
        .s1_axi_rready (rready)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endfunction

    // Monitor: every B/R handshake pops the oldest expectation
    always @(negedge clk) begin
        logic [1:0] eb;
        rexp_t      er;
        if (!rst) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bresp %b with nothing outstanding", bresp);
                end else begin
                    eb = bq.pop_front();
                    check("bresp", {30'd0, bresp}, {30'd0, eb});
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rdata %h with nothing outstanding", rdata);
                end else begin
                    er = rq.pop_front();
                    check("rdata", rdata, er.data);
                    check("rresp", {30'd0, rresp}, {30'd0, er.resp});
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) fail_timeout("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr  = 8'h10; araddr = 8'h14; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    endtask

    // AW and W presented in the same cycle
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int n = 0;
        bq.push_back(er);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_timeout("wr_handshake");
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        check("b_latency", {31'd0, bvalid}, 32'd1);
        drain();
    endtask

    // One of AW/W first, the other gap cycles later
    task automatic wr_split(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit w_first, input int gap);
        bq.push_back(2'b00);
        if (w_first) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        else begin awaddr = a; awvalid = 1'b1; end
        @(negedge clk);
        check("first_rdy", {31'd0, (w_first ? wready : awready)}, 32'd1);
        @(posedge clk);
        #1;
        idle_bus();
        for (int i = 0; i < gap - 1; i++) begin
            @(negedge clk);
            check("b_early", {31'd0, bvalid}, 32'd0);
            check("first_held", {31'd0, (w_first ? wready : awready)}, 32'd0);
            @(posedge clk);
        end
        #1;
        if (w_first) begin awaddr = a; awvalid = 1'b1; end
        else begin wdata = d; wstrb = s; wvalid = 1'b1; end
        @(negedge clk);
        check("second_rdy", {31'd0, (w_first ? awready : wready)}, 32'd1);
        check("b_early", {31'd0, bvalid}, 32'd0);
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        check("b_latency", {31'd0, bvalid}, 32'd1);
        drain();
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        int n = 0;
        rexp_t e;
        e.data = d;
        e.resp = r;
        rq.push_back(e);
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_timeout("rd_handshake");
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        check("r_latency", {31'd0, rvalid}, 32'd1);
        drain();
    endtask

    // Write and read issued in the same cycle; read must see pre-write state
    task automatic coll(input logic [7:0] wa, input logic [31:0] wd, input logic [7:0] ra, input logic [31:0] rexp);
        rexp_t e;
        e.data = rexp;
        e.resp = 2'b00;
        bq.push_back(2'b00);
        rq.push_back(e);
        awaddr = wa; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = ra; arvalid = 1'b1;
        @(negedge clk);
        check("coll_rdy", {29'd0, awready, wready, arready}, 32'h7);
        @(posedge clk);
        #1;
        idle_bus();
        drain();
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready",  {31'd0, wready},  32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_bresp",   {30'd0, bresp},   32'd0);
        check("rst_rresp",   {30'd0, rresp},   32'd0);
        check("rst_rdata",   rdata,            32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bready = 1'b1;
        rready = 1'b1;
        idle_bus();
        #12;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and INFO
        rd(8'h84, 32'h0000_0004, 2'b00);
        rd(8'h00, 32'h0, 2'b00);
        rd(8'h80, 32'h1, 2'b00);

        // Decoupled AW/W, then same-cycle; SUM0 = 39 + 3
        wr_split(8'h00, 32'd39, 4'hF, 1'b0, 3);
        wr(8'h04, 32'd3, 4'hF, 2'b00);
        rd(8'h08, 32'd42, 2'b00);
        rd(8'h0B, 32'd42, 2'b00);
        rd(8'h0C, 32'h0, 2'b00);
        wr_split(8'h34, 32'd7, 4'hF, 1'b1, 2);
        rd(8'h38, 32'd7, 2'b00);

        // Carry, sticky signed overflow, W1C
        wr(8'h10, 32'hFFFF_FFFF, 4'hF, 2'b00);
        wr(8'h14, 32'h0000_0001, 4'hF, 2'b00);
        rd(8'h18, 32'h0, 2'b00);
        rd(8'h1C, 32'h1, 2'b00);
        wr(8'h10, 32'h7FFF_FFFF, 4'hF, 2'b00);
        rd(8'h18, 32'h8000_0000, 2'b00);
        rd(8'h1C, 32'h3, 2'b00);
        wr(8'h1C, 32'h1, 4'hF, 2'b00);
        rd(8'h1C, 32'h2, 2'b00);

        // Byte strobes and EN gating
        wr(8'h20, 32'h1122_3344, 4'hF, 2'b00);
        wr(8'h20, 32'hAABB_CCDD, 4'h5, 2'b00);
        rd(8'h20, 32'h11BB_33DD, 2'b00);
        rd(8'h28, 32'h11BB_33DD, 2'b00);
        wr(8'h80, 32'h0, 4'hF, 2'b00);
        rd(8'h80, 32'h0, 2'b00);
        wr(8'h24, 32'h1, 4'hF, 2'b00);
        rd(8'h24, 32'h1, 2'b00);
        rd(8'h28, 32'h11BB_33DD, 2'b00);
        wr(8'h80, 32'hFFFF_FFFF, 4'hF, 2'b00);
        rd(8'h80, 32'h1, 2'b00);
        rd(8'h28, 32'h11BB_33DD, 2'b00);

        // Error responses, no side effects
        wr(8'h08, 32'h55, 4'hF, 2'b10);
        wr(8'h40, 32'h55, 4'hF, 2'b10);
        wr(8'h84, 32'h55, 4'hF, 2'b10);
        rd(8'h90, 32'h0, 2'b10);
        rd(8'h44, 32'h0, 2'b10);
        rd(8'h08, 32'd42, 2'b00);
        rd(8'h84, 32'h0000_0004, 2'b00);

        // Same-cycle collisions: pre-update SUM, pre-clear STATUS
        coll(8'h00, 32'd100, 8'h08, 32'd42);
        rd(8'h08, 32'd103, 2'b00);
        coll(8'h1C, 32'h2, 8'h1C, 32'h2);
        rd(8'h1C, 32'h0, 2'b00);

        // Backpressure hold, then reset mid-transaction
        bready = 1'b0;
        rready = 1'b0;
        awaddr = 8'h30; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 8'h84; arvalid = 1'b1;
        @(posedge clk);
        #1;
        idle_bus();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valids", {30'd0, bvalid, rvalid}, 32'h3);
            check("hold_readys", {29'd0, awready, wready, arready}, 32'h0);
            check("hold_rdata", rdata, 32'h0000_0004);
            @(posedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        rd(8'h30, 32'h0, 2'b00);
        rd(8'h80, 32'h1, 2'b00);
        rd(8'h18, 32'h0, 2'b00);
        rd(8'h1C, 32'h0, 2'b00);
        rd(8'h20, 32'h0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_adder_bank.md
Name: axi_lite_adder_bank

Overview:
AXI4-Lite slave holding NUM_CH independent adder channels. Each channel has operand registers A and B, a registered SUM, and a sticky STATUS register with carry and signed-overflow flags. A global CTRL/INFO register pair sits above the channels. The bank sits on the s1_axi control bus and is the parametrised, multi-channel successor of the single-adder slave, with full AW/W decoupling, byte strobes and error responses.

Parameters:
DATA_WIDTH, 32, register and bus data width; must be 32.
ADDR_WIDTH, 8, byte address width; must be at least 8.
NUM_CH, 4, number of adder channels, 1..8.

Ports:
s1_axi_aclk  in  1  clock
s1_axi_areset  in  1  asynchronous reset, active-high
s1_axi_awaddr  in  ADDR_WIDTH  write address
s1_axi_awvalid  in  1  write address valid
s1_axi_awready  out  1  write address ready
s1_axi_wdata  in  DATA_WIDTH  write data
s1_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s1_axi_wvalid  in  1  write data valid
s1_axi_wready  out  1  write data ready
s1_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s1_axi_bvalid  out  1  write response valid
s1_axi_bready  in  1  write response ready
s1_axi_araddr  in  ADDR_WIDTH  read address
s1_axi_arvalid  in  1  read address valid
s1_axi_arready  out  1  read address ready
s1_axi_rdata  out  DATA_WIDTH  read data
s1_axi_rresp  out  2  read response
s1_axi_rvalid  out  1  read data valid
s1_axi_rready  in  1  read data ready

Behaviour:
- Register map. Channel c occupies base c*0x10.
  - +0x0 A: RW.
  - +0x4 B: RW.
  - +0x8 SUM: RO.
  - +0xC STATUS: bit0 carry, bit1 signed overflow, W1C.
- Global registers.
  - 0x80 CTRL: RW, bit0 EN, reset value 1; other bits read 0.
  - 0x84 INFO: RO, value {24'h0, NUM_CH[7:0]}.
- Address decode uses awaddr/araddr[7:2] only; bits [1:0] are ignored. Any address not listed above, including channels >= NUM_CH, is unmapped.
- Reset (async, active-high), all outputs and state:
  - Ready signals: awready=1, wready=1, arready=1.
  - Valid signals: bvalid=0, rvalid=0.
  - Responses and data: bresp=00, rresp=00, rdata=0.
  - Registers: A, B, SUM and STATUS all 0; CTRL.EN=1.
  - A reset mid-transaction drops every pending handshake and latched address/data.
- Write path: AW and W are accepted independently, in either order or in the same cycle.
  - awready drops after AW is latched; wready drops after W is latched. Each stays low until the B handshake completes.
  - The cycle after both are held: perform the write, assert bvalid, set bresp.
  - bvalid holds until bready=1. awready and wready return to 1 the cycle after the B handshake.
  - Best-case write latency: AW+W in cycle 0, bvalid in cycle 1.
- Write semantics:
  - Each byte lane with wstrb[i]=1 updates byte i of the target; other bytes are unchanged. wstrb=0 is OKAY with no change.
  - Write to SUM, INFO or an unmapped address: SLVERR, no state change.
  - Write to STATUS: OKAY; clears each flag bit whose strobed data bit is 1.
- Sum pipeline:
  - On any write to A or B of channel c with EN=1, the cycle after the register write: SUM_c = (A_c + B_c) mod 2^32, using the new operand values.
  - In the same cycle, STATUS_c carry |= carry-out and overflow |= signed overflow (sticky).
  - With EN=0, operands still update but SUM and STATUS hold.
  - Setting EN from 0 to 1 does not retrigger a sum.
- Read path: AR accepted when arready=1; arready then drops.
  - Next cycle: rvalid=1 with rdata and rresp. Unmapped address returns rdata=0 and rresp=10.
  - rvalid holds until rready. arready returns to 1 the cycle after the R handshake.
  - rdata is sampled at AR acceptance.
- Collisions:
  - A read of SUM in the same cycle as an operand write returns the pre-update SUM.
  - A read of STATUS in the same cycle as a W1C write returns the pre-clear value.
  - Read and write channels operate fully concurrently.
- Data, strobes and addresses are ignored while the corresponding valid is low.

Test Plan:
1. Reset, then read 0x84 with NUM_CH=4 -> rdata=0x00000004, rresp=00. Read 0x00 -> 0.
2. Write A0=39 with AW issued 3 cycles before W, then write B0=3 with AW+W in the same cycle -> bresp=00 for both. bvalid is 1 cycle after the later of AW/W. Read 0x08 -> 42.
3. Write A1=0xFFFFFFFF, B1=0x00000001 -> SUM1=0, STATUS1=0x1. Then write A1=0x7FFFFFFF -> SUM1=0x80000000, STATUS1=0x3 (sticky, signed overflow set). Write 0x1C with data 0x1, wstrb=0xF -> STATUS1=0x2.
4. Write A2=0x11223344, then write 0xAABBCCDD with wstrb=0x5 -> A2=0x11BB33DD. Write CTRL=0, then write B2=1 -> SUM2 unchanged.
5. Write to 0x08, write to 0x40 (NUM_CH=4), read 0x90 -> bresp=10, bresp=10, rresp=10 with rdata=0; no register changed.
6. Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid held, awready/wready/arready stay 0. Assert reset mid-hold -> all outputs return to reset values.
